// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the iterative divider: latches a divide-class op, holds divider start until ready, then writes back.
// Optional DIV_ZERO_BYPASS_EN resolves divide-by-zero and signed overflow locally without launching the divider.
module div_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [2:0]            req_op_i,
  input  logic [XLEN-1:0]       req_rs1_i,
  input  logic [XLEN-1:0]       req_rs2_i,
  input  logic [REG_ADDR_W-1:0] req_rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  div_start_o,
  output logic [XLEN-1:0]       div_dividend_o,
  output logic [XLEN-1:0]       div_divisor_o,
  output logic [2:0]            div_op_o,
  output logic [REG_ADDR_W-1:0] div_waddr_o,
  input  logic [XLEN-1:0]       div_result_i,
  input  logic                  div_ready_i,
  output logic                  wb_we_o,
  output logic [REG_ADDR_W-1:0] wb_waddr_o,
  output logic [XLEN-1:0]       wb_wdata_o,
  output logic [1:0]            dbg_state
);

  // Handshake: an op is taken in IDLE when req_valid_i & req_op_i[2] & ~flush_i at the clock edge;
  // the request side is held off by stall_o until the op retires (WB) or is cancelled (ABORT).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ABORT = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic            accept;
  logic            bypass_hit;
  logic [XLEN-1:0] bypass_data;

  assign accept    = (state == S_IDLE) & req_valid_i & req_op_i[2] & ~flush_i;
  assign dbg_state = state;

`ifdef DIV_ZERO_BYPASS_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // op[1] selects remainder, op[0] selects unsigned; overflow only exists for signed ops.
  always_comb begin
    bypass_hit  = 1'b0;
    bypass_data = '0;
    if (req_rs2_i == '0) begin
      bypass_hit  = 1'b1;
      bypass_data = req_op_i[1] ? req_rs1_i : '1;
    end else if (!req_op_i[0] && (req_rs1_i == INT_MIN) && (req_rs2_i == '1)) begin
      bypass_hit  = 1'b1;
      bypass_data = req_op_i[1] ? '0 : INT_MIN;
    end
  end
`else
  assign bypass_hit  = 1'b0;
  assign bypass_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = bypass_hit ? S_WB : S_ISSUE;
      end
      S_ISSUE: begin
        if (flush_i)          state_nxt = S_ABORT;
        else if (div_ready_i) state_nxt = S_WB;
      end
      S_ABORT: state_nxt = S_IDLE;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Start drops in the ready cycle so the divider sees it low before it could re-launch.
  always_comb begin
    stall_o     = 1'b0;
    div_start_o = 1'b0;
    wb_we_o     = 1'b0;
    case (state)
      S_IDLE:  stall_o = accept;
      S_ISSUE: begin
        stall_o     = 1'b1;
        div_start_o = ~div_ready_i & ~flush_i;
      end
      S_ABORT: stall_o = 1'b1;
      S_WB:    wb_we_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_op_o       <= '0;
      div_waddr_o    <= '0;
    end else if (accept) begin
      div_dividend_o <= req_rs1_i;
      div_divisor_o  <= req_rs2_i;
      div_op_o       <= req_op_i;
      div_waddr_o    <= req_rd_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wdata_o <= '0;
    end else if (accept && bypass_hit) begin
      wb_wdata_o <= bypass_data;
    end else if ((state == S_ISSUE) && div_ready_i && !flush_i) begin
      wb_wdata_o <= div_result_i;
    end
  end

  assign wb_waddr_o = div_waddr_o;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural iterative-divider responder and a writeback scoreboard.
module tb_div_issue_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] req_rs1_i;
  logic [XLEN-1:0] req_rs2_i;
  logic [AW-1:0]   req_rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            div_start_o;
  logic [XLEN-1:0] div_dividend_o;
  logic [XLEN-1:0] div_divisor_o;
  logic [2:0]      div_op_o;
  logic [AW-1:0]   div_waddr_o;
  logic [XLEN-1:0] div_result_i;
  logic            div_ready_i;
  logic            wb_we_o;
  logic [AW-1:0]   wb_waddr_o;
  logic [XLEN-1:0] wb_wdata_o;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int launches = 0;
  int div_lat  = 4;
  logic [XLEN-1:0] exp_q[$];

  div_issue_ctrl #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_rs1_i(req_rs1_i),
    .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_op_o(div_op_o), .div_waddr_o(div_waddr_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension division semantics, used only by the divider responder.
  function automatic logic [XLEN-1:0] div_ref(input logic [2:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op[1:0])
      2'b00:   r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : XLEN'($signed(a) / $signed(b));
      2'b01:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   r = (b == 0) ? a : ovf ? 32'h0 : XLEN'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Divider responder: launches when start is sampled while idle, pulses ready after div_lat busy
  // edges, cancels if start drops while busy. Start seen high in the ready cycle counts as a relaunch.
  logic busy = 1'b0;
  int   cnt  = 0;
  always @(posedge clk) begin
    logic st, rdy;
    st  = div_start_o;
    rdy = div_ready_i;
    #1;
    if (rst) begin
      busy        = 1'b0;
      div_ready_i = 1'b0;
    end else if (rdy) begin
      div_ready_i = 1'b0;
      busy        = 1'b0;
      if (st) launches++;
    end else if (!busy) begin
      if (st) begin
        busy = 1'b1;
        cnt  = div_lat;
        launches++;
      end
    end else if (!st) begin
      busy = 1'b0;
    end else begin
      cnt--;
      if (cnt == 0) begin
        div_ready_i  = 1'b1;
        div_result_i = div_ref(div_op_o, div_dividend_o, div_divisor_o);
      end
    end
  end

  // scoreboard: every writeback pulse must match the oldest expected value
  always @(negedge clk) begin
    if (!rst && wb_we_o === 1'b1) begin
      if (exp_q.size() == 0) check_eq("wb_unexpected", wb_we_o, 1'b0);
      else                   check_eq("wb_wdata", wb_wdata_o, exp_q.pop_front());
    end
  end

  // driver: issue one op and follow it to writeback; special marks a bypassable operand pair
  task automatic do_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [AW-1:0] rd,
                       input logic [XLEN-1:0] exp, input bit special);
    int k, l0, exp_k, exp_l;
    bit start_ok, stall_ok, wb_seen;
    bit local_path;
    local_path = BYPASS && special;
    // accept cycle, one ISSUE cycle before the divider samples start, div_lat busy cycles, ready, WB
    exp_k    = local_path ? 1 : div_lat + 3;
    exp_l    = local_path ? 0 : 1;
    l0       = launches;
    start_ok = 1'b1;
    stall_ok = 1'b1;
    wb_seen  = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_rs1_i   = a;
    req_rs2_i   = b;
    req_rd_i    = rd;
    #1;
    check_eq({tag, "_stall_accept"}, stall_o, 1'b1);
    k = 0;
    while (!wb_seen && k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (wb_we_o) begin
        wb_seen = 1'b1;
      end else begin
        if (!stall_o) stall_ok = 1'b0;
        if (dbg_state == ST_ISSUE && div_start_o !== !div_ready_i) start_ok = 1'b0;
        if (k == 1) begin
          check_eq({tag, "_dividend"}, div_dividend_o, a);
          check_eq({tag, "_divisor"}, div_divisor_o, b);
          check_eq({tag, "_op"}, div_op_o, op);
        end
      end
    end
    check_eq({tag, "_wb_seen"}, wb_seen, 1'b1);
    check_eq({tag, "_latency"}, k, exp_k);
    check_eq({tag, "_wb_waddr"}, wb_waddr_o, rd);
    check_eq({tag, "_stall_wb"}, stall_o, 1'b0);
    check_eq({tag, "_state_wb"}, dbg_state, ST_WB);
    check_eq({tag, "_start_hold"}, start_ok, 1'b1);
    check_eq({tag, "_stall_hold"}, stall_ok, 1'b1);
    check_eq({tag, "_launches"}, launches - l0, exp_l);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check_eq({tag, "_no_reaccept"}, dbg_state, ST_IDLE);
    check_eq({tag, "_wb_we_low"}, wb_we_o, 1'b0);
  endtask

  initial begin
    int l0;
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    req_op_i     = '0;
    req_rs1_i    = '0;
    req_rs2_i    = '0;
    req_rd_i     = '0;
    flush_i      = 1'b0;
    div_result_i = '0;
    div_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_stall", stall_o, 1'b0);
    check_eq("rst_start", div_start_o, 1'b0);
    check_eq("rst_wb_we", wb_we_o, 1'b0);
    check_eq("rst_wdata", wb_wdata_o, 32'h0);
    check_eq("rst_dividend", div_dividend_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);

    // op outside the divide class is ignored
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 3'b000;
    req_rs1_i   = 32'd3;
    req_rs2_i   = 32'd4;
    #1;
    check_eq("mul_stall", stall_o, 1'b0);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check_eq("mul_state", dbg_state, ST_IDLE);

    // flush in the tenth ISSUE cycle
    div_lat = 12;
    l0      = launches;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 3'b100;
    req_rs1_i   = 32'd20;
    req_rs2_i   = 32'd4;
    req_rd_i    = 5'd8;
    repeat (10) @(negedge clk);
    flush_i     = 1'b1;
    req_valid_i = 1'b0;
    #1;
    check_eq("flush_state", dbg_state, ST_ISSUE);
    check_eq("flush_start", div_start_o, 1'b0);
    check_eq("flush_stall", stall_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check_eq("abort_state", dbg_state, ST_ABORT);
    check_eq("abort_start", div_start_o, 1'b0);
    check_eq("abort_stall", stall_o, 1'b1);
    check_eq("abort_wb_we", wb_we_o, 1'b0);
    @(negedge clk);
    #1;
    check_eq("abort_exit", dbg_state, ST_IDLE);
    check_eq("abort_stall_exit", stall_o, 1'b0);
    check_eq("abort_launches", launches - l0, 1);
    div_lat = 4;
    do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd10, 32'd3, 1'b0);

    // special operand pairs
    do_op("div_by_zero", 3'b100, 32'h0000_1234, 32'h0, 5'd7, 32'hFFFF_FFFF, 1'b1);
    do_op("remu_by_zero", 3'b111, 32'h0000_0055, 32'h0, 5'd11, 32'h0000_0055, 1'b1);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, 1'b1);
    do_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 1'b0);

    // reset in the middle of ISSUE
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 3'b101;
    req_rs1_i   = 32'd100;
    req_rs2_i   = 32'd7;
    req_rd_i    = 5'd15;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_rst_state", dbg_state, ST_ISSUE);
    rst         = 1'b1;
    req_valid_i = 1'b0;
    #1;
    check_eq("mid_rst_state", dbg_state, ST_IDLE);
    check_eq("mid_rst_start", div_start_o, 1'b0);
    check_eq("mid_rst_stall", stall_o, 1'b0);
    check_eq("mid_rst_wb_we", wb_we_o, 1'b0);
    check_eq("mid_rst_dividend", div_dividend_o, 32'h0);
    check_eq("mid_rst_waddr", wb_waddr_o, 5'd0);
    check_eq("mid_rst_wdata", wb_wdata_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op("divu_6_3", 3'b101, 32'd6, 32'd3, 5'd9, 32'd2, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
